// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand/result width in bits
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Single-bit half subtractor: computes a - b without a borrow-in.
// Ports:
//   a      in  minuend bit
//   b      in  subtrahend bit
//   diff   out a ^ b
//   borrow out 1 when a = 0 and b = 1
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Operands are accepted over a valid/ready
// handshake, subtracted LSB-first one bit per clock through a full
// subtractor built from two half subtractors, and the WIDTH-bit difference
// plus final borrow is returned over a second valid/ready handshake.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready high only in IDLE)
//   a, b                 minuend, subtrahend (unsigned, WIDTH bits)
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   diff                 (a - b) mod 2^WIDTH
//   borrow_out           1 iff a < b
//   busy                 high in RUN or DONE
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sd;
  logic [CW-1:0]    cnt;
  logic             bw;

  logic             accept;
  logic             last_bit;
  logic             d1, b1, d, b2;

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Per-bit full subtractor: x - y - bw.
  half_subtractor u_hs_xy (
    .a      (sa[0]),
    .b      (sb[0]),
    .diff   (d1),
    .borrow (b1)
  );

  half_subtractor u_hs_bw (
    .a      (d1),
    .b      (bw),
    .diff   (d),
    .borrow (b2)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so diff/borrow_out read zero
  // after reset instead of leftovers from an aborted operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sd  <= '0;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      sd  <= '0;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      // New difference bit enters at the MSB; written as shift/or so that
      // WIDTH = 1 needs no zero-width slice.
      sd  <= (sd >> 1) | (WIDTH'(d) << (WIDTH - 1));
      bw  <= b1 | b2;
      cnt <= cnt + CW'(1);
    end
  end

  // Handshake/status outputs decode the state register only.
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign busy       = (state == RUN) || (state == DONE);
  assign diff       = sd;
  assign borrow_out = bw;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 1, 8 and 13.
// Expected {borrow, diff} values come from an arithmetic reference model and
// travel through a scoreboard queue from accept to result handshake.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH = 1 instance
  logic        iv1, ir1, ov1, or1, bo1, bz1;
  logic [0:0]  a1, b1, d1;
  // WIDTH = 8 instance
  logic        iv8, ir8, ov8, or8, bo8, bz8;
  logic [7:0]  a8, b8, d8;
  // WIDTH = 13 instance
  logic        iv13, ir13, ov13, or13, bo13, bz13;
  logic [12:0] a13, b13, d13;

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .diff(d1), .borrow_out(bo1), .busy(bz1));

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8), .busy(bz8));

  serial_subtractor #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv13), .in_ready(ir13), .a(a13), .b(b13),
    .out_valid(ov13), .out_ready(or13), .diff(d13), .borrow_out(bo13), .busy(bz13));

  int n_cmp = 0;
  int n_bad = 0;
  logic [13:0] sb_q[$];   // {borrow, 13-bit zero-extended diff}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instance selection helpers (s = instance width).
  task automatic set_in(input int s, input logic v, input logic [12:0] a, input logic [12:0] b);
    case (s)
      1:       begin iv1  = v; a1  = a[0:0]; b1  = b[0:0]; end
      13:      begin iv13 = v; a13 = a;      b13 = b;      end
      default: begin iv8  = v; a8  = a[7:0]; b8  = b[7:0]; end
    endcase
  endtask

  task automatic set_ordy(input int s, input logic v);
    case (s)
      1:       or1  = v;
      13:      or13 = v;
      default: or8  = v;
    endcase
  endtask

  function automatic logic rdy(input int s);
    case (s)
      1:       return ir1;
      13:      return ir13;
      default: return ir8;
    endcase
  endfunction

  function automatic logic vld(input int s);
    case (s)
      1:       return ov1;
      13:      return ov13;
      default: return ov8;
    endcase
  endfunction

  function automatic logic bsy(input int s);
    case (s)
      1:       return bz1;
      13:      return bz13;
      default: return bz8;
    endcase
  endfunction

  function automatic logic [13:0] res(input int s);
    case (s)
      1:       return {bo1,  13'(d1)};
      13:      return {bo13, d13};
      default: return {bo8,  13'(d8)};
    endcase
  endfunction

  // One complete operation on instance s of width w. hold = cycles out_ready
  // stays low after out_valid rises; junk = drive different operands with
  // in_valid high while the operation is in flight.
  task automatic run_op(input int s, input int w, input logic [12:0] a,
                        input logic [12:0] b, input int hold, input bit junk);
    int          guard;
    logic [13:0] full, exp, held;
    full = {1'b0, a} - {1'b0, b};
    exp  = {full[w], 13'(full & ((14'd1 << w) - 14'd1))};

    set_ordy(s, hold == 0);
    set_in(s, 1'b1, a, b);
    guard = 0;
    while (!rdy(s) && guard < 100) begin @(posedge clk); #1; guard++; end
    check("accept_wait", 32'(guard < 100), 32'd1);
    @(posedge clk); #1;                       // accept edge k
    sb_q.push_back(exp);
    if (junk) set_in(s, 1'b1, ~a, ~b);
    else      set_in(s, 1'b0, a, b);
    check("busy_run", 32'(bsy(s)), 32'd1);
    check("in_ready_run", 32'(rdy(s)), 32'd0);

    guard = 0;
    while (!vld(s) && guard < 100) begin @(posedge clk); #1; guard++; end
    check("latency", guard, w);

    held = res(s);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(vld(s)), 32'd1);
      check("bp_stable", 32'(res(s)), 32'(held));
      check("bp_in_ready", 32'(rdy(s)), 32'd0);
    end
    set_ordy(s, 1'b1);

    if (sb_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
    else check("result", 32'(res(s)), 32'(sb_q.pop_front()));

    @(posedge clk); #1;                       // result handshake edge
    check("valid_drops", 32'(vld(s)), 32'd0);
    check("ready_back", 32'(rdy(s)), 32'd1);
    check("busy_clear", 32'(bsy(s)), 32'd0);  // also shows junk was never taken
    set_in(s, 1'b0, a, b);
  endtask

  initial begin
    int  guard;
    bit  seen;
    iv1 = 0; a1 = '0; b1 = '0; or1 = 1;
    iv8 = 0; a8 = '0; b8 = '0; or8 = 1;
    iv13 = 0; a13 = '0; b13 = '0; or13 = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(ir8), 32'd1);
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_busy", 32'(bz8), 32'd0);
    check("rst_diff", 32'(d8), 32'd0);
    check("rst_borrow", 32'(bo8), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH = 8 cases
    run_op(8, 8, 13'h5A, 13'h3C, 0, 1'b0);    // 0x1E, no borrow
    run_op(8, 8, 13'h00, 13'h01, 0, 1'b0);    // 0xFF, borrow
    run_op(8, 8, 13'hA5, 13'hA5, 0, 1'b0);    // 0x00, no borrow
    run_op(8, 8, 13'h10, 13'h20, 5, 1'b0);    // backpressure, 0xF0 borrow
    run_op(8, 8, 13'h33, 13'h11, 0, 1'b1);    // operands during RUN ignored

    // Reset in the middle of RUN
    set_ordy(8, 1'b1);
    set_in(8, 1'b1, 13'h55, 13'h0A);
    @(posedge clk); #1;                       // accepted (block was idle)
    set_in(8, 1'b0, 13'h00, 13'h00);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_abort_busy", 32'(bz8), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(ov8), 32'd0);
    check("abort_in_ready", 32'(ir8), 32'd1);
    check("abort_busy", 32'(bz8), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (guard = 0; guard < 15; guard++) begin
      @(posedge clk); #1;
      if (ov8) seen = 1'b1;
    end
    check("no_result_after_abort", 32'(seen), 32'd0);
    run_op(8, 8, 13'h07, 13'h03, 0, 1'b0);    // 0x04

    // Random sweeps against the reference model
    for (int i = 0; i < 12; i++)
      run_op(1, 1, 13'($urandom_range(0, 1)), 13'($urandom_range(0, 1)), 0, 1'b0);
    for (int i = 0; i < 30; i++)
      run_op(8, 8, 13'($urandom_range(0, 255)), 13'($urandom_range(0, 255)),
             (i % 5 == 0) ? 2 : 0, 1'b0);
    run_op(13, 13, 13'h0000, 13'h1FFF, 0, 1'b0);
    run_op(13, 13, 13'h1FFF, 13'h0000, 0, 1'b0);
    for (int i = 0; i < 25; i++)
      run_op(13, 13, 13'($urandom_range(0, 8191)), 13'($urandom_range(0, 8191)),
             (i % 7 == 0) ? 1 : 0, 1'b0);

    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
